// File: rtl/i2s_tx_framer.sv
// i2s_tx_framer: stereo I2S / left-justified DAC serializer with a one-entry sample hold buffer.
// Frames run back-to-back while enabled; each frame loads the held sample or plays silence.
module i2s_tx_framer #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    parameter bit I2S_MODE   = 1'b1
) (
    input  logic                  BCLK,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] left_data,
    input  logic [DATA_WIDTH-1:0] rigth_data,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  DACLRC,
    output logic                  DACDAT,
    output logic                  frame_start,
    output logic                  underrun,
    output logic                  underrun_seen
);
    localparam int CW = $clog2(2 * SLOT_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(2 * SLOT_WIDTH - 1);
    localparam logic [CW-1:0] SW_C = CW'(SLOT_WIDTH);
    localparam logic [DATA_WIDTH-1:0] MSB = DATA_WIDTH'(1) << (DATA_WIDTH - 1);

    if (SLOT_WIDTH < DATA_WIDTH) begin : g_width_check
        $error("i2s_tx_framer: SLOT_WIDTH must be >= DATA_WIDTH");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state;
    logic [CW-1:0]         cnt, nc, s;
    logic [DATA_WIDTH-1:0] hold_l, hold_r, act_l, act_r, nl, nr;
    logic                  load, run_next, empty_load, right, lj, lj_q;

    // nc/nl/nr describe the position and data the registered outputs will show after this edge;
    // sample_ready doubles as the "hold buffer empty" flag.
    always_comb begin
        load       = enable && (state == IDLE || cnt == LAST);
        run_next   = load || (state == RUN && cnt != LAST);
        empty_load = load && sample_ready;
        nl         = load ? (sample_ready ? '0 : hold_l) : act_l;
        nr         = load ? (sample_ready ? '0 : hold_r) : act_r;
        nc         = load ? '0 : cnt + 1'b1;
        right      = nc >= SW_C;
        s          = right ? nc - SW_C : nc;
        lj         = |((right ? nr : nl) & (MSB >> s));
    end

    // MSB >> s runs out of the word for s >= DATA_WIDTH, which yields the slot padding zeros.
    always_ff @(posedge BCLK) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            hold_l        <= '0;
            hold_r        <= '0;
            act_l         <= '0;
            act_r         <= '0;
            lj_q          <= 1'b0;
            sample_ready  <= 1'b1;
            DACLRC        <= 1'b0;
            DACDAT        <= 1'b0;
            frame_start   <= 1'b0;
            underrun      <= 1'b0;
            underrun_seen <= 1'b0;
        end else begin
            frame_start   <= load;
            underrun      <= empty_load;
            underrun_seen <= underrun_seen || empty_load;
            sample_ready  <= (sample_ready || load) && !(sample_valid && sample_ready);
            if (sample_valid && sample_ready) begin
                hold_l <= left_data;
                hold_r <= rigth_data;
            end
            state  <= run_next ? RUN : IDLE;
            cnt    <= run_next ? nc : '0;
            act_l  <= nl;
            act_r  <= nr;
            DACLRC <= run_next && right;
            lj_q   <= run_next && lj;
            DACDAT <= I2S_MODE ? lj_q : (run_next && lj);
        end
    end
endmodule
